// File: rtl/bullet_pool_if.sv
// bullet_pool_if: spawn, per-slot control, slot state and pixel-query signals of bullet_pool.
// Direction encoding UP=0 DOWN=1 LEFT=2 RIGHT=3; colour BULLET=1, BACKGROUND=0.
interface bullet_pool_if #(
   parameter int NUM_BULLETS = 4,
   parameter int COORD_W = 10,
   parameter int STEP_W = 8,
   parameter int LIFE_W = 8
);
   localparam int SLOT_W = NUM_BULLETS > 1 ? $clog2(NUM_BULLETS) : 1;
   localparam int CNT_W = $clog2(NUM_BULLETS + 1);
   logic spawnReq;
   logic [1:0] spawnDir;
   logic [COORD_W-1:0] spawnX, spawnY;
   logic spawnAck;
   logic [SLOT_W-1:0] spawnSlot;
   logic spawnDrop;
   logic [STEP_W-1:0] bulletStep;
   logic [LIFE_W-1:0] bulletLife;
   logic [NUM_BULLETS-1:0] sigKill, sigBounce, bulletExists;
   logic [NUM_BULLETS*COORD_W-1:0] bulletPosX, bulletPosY;
   logic [CNT_W-1:0] liveCount;
   logic [COORD_W-1:0] pixelPosX, pixelPosY;
   logic bulletColor;
   logic [SLOT_W-1:0] pixelHitIdx;
   modport master (
      output spawnReq, spawnDir, spawnX, spawnY, bulletStep, bulletLife, sigKill, sigBounce,
             pixelPosX, pixelPosY,
      input  spawnAck, spawnSlot, spawnDrop, bulletExists, bulletPosX, bulletPosY, liveCount,
             bulletColor, pixelHitIdx
   );
   modport slave (
      input  spawnReq, spawnDir, spawnX, spawnY, bulletStep, bulletLife, sigKill, sigBounce,
             pixelPosX, pixelPosY,
      output spawnAck, spawnSlot, spawnDrop, bulletExists, bulletPosX, bulletPosY, liveCount,
             bulletColor, pixelHitIdx
   );
endinterface

// File: rtl/bullet_pool.sv
// bullet_pool: frame-stepped pool of wall-bouncing bullets with lowest-free spawn allocation
// and a combinational pixel hit test.
module bullet_pool #(
   parameter int NUM_BULLETS = 4,
   parameter int COORD_W = 10,
   parameter int STEP_W = 8,
   parameter int LIFE_W = 8,
   parameter int RADIUS = 3,
   parameter int MAX_X = 639,
   parameter int MAX_Y = 479
) (
   input logic frameClk,
   input logic reset,
   bullet_pool_if.slave bus
);
   localparam int N = NUM_BULLETS;
   localparam int SW = N > 1 ? $clog2(N) : 1;
   localparam int CNT_W = $clog2(N + 1);
   localparam int W = COORD_W + 1;
   localparam logic signed [W-1:0] XLO = W'(RADIUS);
   localparam logic signed [W-1:0] YLO = W'(RADIUS);
   localparam logic signed [W-1:0] XHI = W'(MAX_X - RADIUS);
   localparam logic signed [W-1:0] YHI = W'(MAX_Y - RADIUS);
   localparam logic signed [W-1:0] RAD = W'(RADIUS);
   localparam logic [1:0] UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3;
   logic [N-1:0] exists_q, exists_d, hit;
   logic [CNT_W-1:0] live_q, live_d;
   logic [SW-1:0] slot, hit_idx;
   logic ack;
   logic signed [W-1:0] rx, ry, sx, sy;
   assign rx = signed'({1'b0, bus.spawnX});
   assign ry = signed'({1'b0, bus.spawnY});
   assign sx = rx < XLO ? XLO : rx > XHI ? XHI : rx;
   assign sy = ry < YLO ? YLO : ry > YHI ? YHI : ry;
   assign ack = reset && bus.spawnReq && !(&exists_q);
   always_comb begin
      slot = '0;
      hit_idx = '0;
      for (int i = N - 1; i >= 0; i--) begin
         slot = !exists_q[i] ? SW'(i) : slot;
         hit_idx = hit[i] ? SW'(i) : hit_idx;
      end
      live_d = '0;
      for (int i = 0; i < N; i++) live_d = live_d + CNT_W'(exists_d[i]);
   end
   always_ff @(posedge frameClk) live_q <= !reset ? '0 : live_d;
   for (genvar g = 0; g < N; g++) begin : g_slot
      logic e_q, e_d;
      logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
      logic [1:0] d_q, d_d;
      logic [LIFE_W-1:0] l_q, l_d;
      logic [LIFE_W:0] c_q, c_d;
      logic signed [W-1:0] s, mx, my, dx, dy;
      logic hold, wall, bounce;
      // Candidate is formed at COORD_W+1 signed bits so an underflow reads as below the wall.
      always_comb begin
         s = W'(bus.bulletStep);
         mx = signed'({1'b0, x_q});
         my = signed'({1'b0, y_q});
         mx = d_q == RIGHT ? mx + s : d_q == LEFT ? mx - s : mx;
         my = d_q == DOWN ? my + s : d_q == UP ? my - s : my;
         wall = mx < XLO || mx > XHI || my < YLO || my > YHI;
         hold = bus.sigKill[g] || bus.sigBounce[g];
         bounce = !bus.sigKill[g] && (bus.sigBounce[g] || wall);
         e_d = e_q;
         x_d = x_q;
         y_d = y_q;
         d_d = d_q;
         l_d = l_q;
         c_d = c_q;
         if (ack && slot == SW'(g)) begin
            e_d = 1'b1;
            x_d = COORD_W'(sx);
            y_d = COORD_W'(sy);
            d_d = bus.spawnDir;
            l_d = bus.bulletLife;
            c_d = '0;
         end else if (e_q) begin
            x_d = hold ? x_q : COORD_W'(mx < XLO ? XLO : mx > XHI ? XHI : mx);
            y_d = hold ? y_q : COORD_W'(my < YLO ? YLO : my > YHI ? YHI : my);
            d_d = bounce ? {d_q[1], ~d_q[0]} : d_q;
            c_d = bounce ? c_q + 1'b1 : c_q;
            e_d = !bus.sigKill[g] && !(bounce && c_q + 1'b1 > {1'b0, l_q});
         end
      end
      always_ff @(posedge frameClk) begin
         if (!reset) begin
            e_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            d_q <= RIGHT;
            l_q <= '0;
            c_q <= '0;
         end else begin
            e_q <= e_d;
            x_q <= x_d;
            y_q <= y_d;
            d_q <= d_d;
            l_q <= l_d;
            c_q <= c_d;
         end
      end
      assign dx = signed'({1'b0, bus.pixelPosX}) - signed'({1'b0, x_q});
      assign dy = signed'({1'b0, bus.pixelPosY}) - signed'({1'b0, y_q});
      assign hit[g] = e_q && dx >= -RAD && dx <= RAD && dy >= -RAD && dy <= RAD;
      assign exists_q[g] = e_q;
      assign exists_d[g] = e_d;
      assign bus.bulletPosX[g*COORD_W +: COORD_W] = x_q;
      assign bus.bulletPosY[g*COORD_W +: COORD_W] = y_q;
   end
   assign bus.spawnAck = ack;
   assign bus.spawnSlot = slot;
   assign bus.spawnDrop = bus.spawnReq && (&exists_q);
   assign bus.bulletExists = exists_q;
   assign bus.liveCount = live_q;
   assign bus.bulletColor = |hit;
   assign bus.pixelHitIdx = hit_idx;
endmodule
